// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and helpers.
// Patterns are active-high with bit 0 = a through bit 6 = g.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_ALL   = 7'h7f;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3f, 7'h06, 7'h5b, 7'h4f,
    7'h66, 7'h6d, 7'h7d, 7'h07,
    7'h7f, 7'h6f, 7'h77, 7'h7c,
    7'h39, 7'h5e, 7'h79, 7'h71
  };

  function automatic logic [6:0] seg_pol(
    input logic [6:0] s,
    input logic       low
  );
    return low ? ~s : s;
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Display bundle: host-side controls plus the scanned LED drive.
// The master drives data/controls, the slave is the scanner.
interface seg7_scan_if #(
  parameter int NDIG     = 4,
  parameter int DIM_BITS = 3
);
  logic                load;
  logic [4*NDIG-1:0]   word;
  logic [NDIG-1:0]     dp_in;
  logic                lz_blank;
  logic [DIM_BITS-1:0] bright;
  logic [6:0]          seg;
  logic                dp;
  logic [NDIG-1:0]     an;
  logic                frame;

  modport master (
    output load, word, dp_in, lz_blank, bright,
    input  seg, dp, an, frame
  );

  modport slave (
    input  load, word, dp_in, lz_blank, bright,
    output seg, dp, an, frame
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-high segment decoder.
// Polarity is left to the caller.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_HEX[nib];
  end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed 7-segment scanner with frame-aligned double buffering,
// PWM dimming, dead-time ghost suppression and leading-zero blanking.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int PSC_W       = 10,
  parameter int DIM_BITS    = 3,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic [4*NDIG-1:0]   word,
  input  logic [NDIG-1:0]     dp_in,
  input  logic                lz_blank,
  input  logic [DIM_BITS-1:0] bright,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [NDIG-1:0]     an,
  output logic                frame
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);
  localparam logic SLOW = (SEG_ACT_LOW != 0);
  localparam logic ALOW = (AN_ACT_LOW != 0);

  logic [PSC_W-1:0]  psc;
  logic [IW-1:0]     idx;
  logic [4*NDIG-1:0] pend_w;
  logic [NDIG-1:0]   pend_dp;
  logic [4*NDIG-1:0] shad_w;
  logic [NDIG-1:0]   shad_dp;
  logic              tick;
  logic              wrap;

  assign tick = &psc;
  assign wrap = tick && (idx == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psc     <= '0;
      idx     <= '0;
      pend_w  <= '0;
      pend_dp <= '0;
      shad_w  <= '0;
      shad_dp <= '0;
    end else begin
      psc <= psc + 1'b1;
      if (tick)
        idx <= wrap ? '0 : idx + 1'b1;
      if (load) begin
        pend_w  <= word;
        pend_dp <= dp_in;
      end
      // A load on the wrap tick bypasses pending so it is not lost.
      if (wrap) begin
        shad_w  <= load ? word  : pend_w;
        shad_dp <= load ? dp_in : pend_dp;
      end
    end
  end

  logic [3:0]      nib;
  logic            dp_bit;
  logic            zpre;
  logic            blank;
  logic            lit;
  logic [NDIG-1:0] an_on;
  logic [6:0]      dec;

  always_comb begin
    nib    = 4'h0;
    dp_bit = 1'b0;
    zpre   = 1'b1;
    for (int j = 0; j < NDIG; j++) begin
      if (idx == IW'(j)) begin
        nib    = shad_w[4*(NDIG-1-j) +: 4];
        dp_bit = shad_dp[NDIG-1-j];
      end
      if (IW'(j) <= idx && shad_w[4*(NDIG-1-j) +: 4] != 4'h0)
        zpre = 1'b0;
    end
  end

  assign blank = lz_blank && (idx != LAST) && zpre;
  assign lit   = (psc != '0) && !blank &&
                 (bright >= psc[PSC_W-1 -: DIM_BITS]);

  always_comb begin
    an_on = '0;
    for (int j = 0; j < NDIG; j++)
      if (idx == IW'(j))
        an_on[NDIG-1-j] = lit;
  end

  seg7_decode u_dec (
    .nib (nib),
    .seg (dec)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg   <= seg_pol(SEG_BLANK, SLOW);
      dp    <= SLOW;
      an    <= {NDIG{ALOW}};
      frame <= 1'b0;
    end else begin
      seg   <= seg_pol(lit ? dec : SEG_BLANK, SLOW);
      dp    <= (lit & dp_bit) ^ SLOW;
      an    <= ALOW ? ~an_on : an_on;
      frame <= wrap;
    end
  end

endmodule
